dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 194 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: serves single-outstanding CPU load/store requests
// against on-chip word RAM, a byte-input FIFO data register and a status register.
module dmem_responder #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready
);

    // state   | meaning
    // IDLE    | ready for a request
    // RD_WAIT | synchronous RAM read in flight
    // RESP    | rsp_valid asserted for this single cycle
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [31:0]   RAM_BYTES   = 32'(RAM_WORDS * 4);
    localparam logic [31:0]   STATUS_ADDR = IO_BASE + 32'd4;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);

    logic [1:0]    state;

    logic [31:0]   ram_mem [RAM_WORDS];
    logic [31:0]   ram_q;
    logic [AW-1:0] ram_idx;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    count8;

    logic          sel_ram;
    logic          sel_fifo;
    logic          sel_stat;
    logic          sel_err;

    logic          accept;
    logic          ram_we;
    logic          ram_re;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;

    logic [31:0]   status_word;
    logic [31:0]   load_data;
    logic          load_err;

    assign req_ready  = (state == S_IDLE);
    assign accept     = req_valid && req_ready;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;

    // Misalignment takes priority over every address range.
    always_comb begin
        sel_ram  = 1'b0;
        sel_fifo = 1'b0;
        sel_stat = 1'b0;
        sel_err  = 1'b0;
        if (req_addr[1:0] != 2'b00) begin
            sel_err = 1'b1;
        end else if (req_addr < RAM_BYTES) begin
            sel_ram = 1'b1;
        end else if (req_addr == IO_BASE) begin
            sel_fifo = 1'b1;
        end else if (req_addr == STATUS_ADDR) begin
            sel_stat = 1'b1;
        end else begin
            sel_err = 1'b1;
        end
    end

    assign ram_idx = req_addr[AW+1:2];
    assign ram_we  = accept && req_we && sel_ram;
    assign ram_re  = accept && !req_we && sel_ram;
    assign pop     = accept && !req_we && sel_fifo && !fifo_empty;

    // RAM is never cleared; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (rstn && ram_we) begin
            ram_mem[ram_idx] <= req_wdata;
        end
        if (ram_re) begin
            ram_q <= ram_mem[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    assign count8      = 8'(count);
    assign status_word = {16'b0, count8, 6'b0, fifo_full, !fifo_empty};

    // Immediate result for every access that does not need the RAM read cycle.
    always_comb begin
        load_data = '0;
        load_err  = 1'b0;
        if (sel_err) begin
            load_err = 1'b1;
        end else if (!req_we) begin
            if (sel_fifo && !fifo_empty) begin
                load_data = {24'b0, fifo_mem[rd_ptr]};
            end else if (sel_stat) begin
                load_data = status_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (ram_re) begin
                            state <= S_RD_WAIT;
                        end else begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= load_data;
                            rsp_err   <= load_err;
                        end
                    end
                end
                S_RD_WAIT: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ram_q;
                    rsp_err   <= 1'b0;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver queues expected responses at
// accept time, a monitor pops and compares data, error flag and latency.
module tb_dmem_responder;

    localparam logic [31:0] IO_BASE = 32'hFFFF0000;
    localparam logic [31:0] IO_STAT = 32'hFFFF0004;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t     exp_q[$];
    logic [7:0] feed_q[$];
    int       cyc = 0;
    int       checks = 0;
    int       failures = 0;
    int       last_acc = 0;
    int       last_lat = 0;

    dmem_responder #(
        .RAM_WORDS (1024),
        .FIFO_DEPTH(8),
        .IO_BASE   (IO_BASE)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input string name, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input bit exp_err, input int lat, input bit expect_rsp,
                         input bit hold, input bit chk_gap);
        int   budget;
        int   acc;
        exp_t e;
        budget    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            check32({name, "_accept_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc;
        if (chk_gap) check32({name, "_gap"}, 32'(acc - last_acc), 32'(last_lat + 1));
        last_acc = acc;
        last_lat = lat;
        if (expect_rsp) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.cyc   = acc + lat;
            e.name  = name;
            exp_q.push_back(e);
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic feed();
        int stall;
        stall = 0;
        while (feed_q.size() > 0 && stall < 100) begin
            in_valid = 1'b1;
            in_data  = feed_q[0];
            if (in_ready) begin
                void'(feed_q.pop_front());
                stall = 0;
            end else begin
                stall++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (feed_q.size() > 0) check32("feed_timeout", 32'(feed_q.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check32("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check32({e.name, "_rdata"}, rsp_rdata, e.rdata);
                    check32({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
                    check32({e.name, "_lat"}, 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;

        // Reset state
        idle(3);
        check32("rst_req_ready", 32'(req_ready), 32'd1);
        check32("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check32("rst_rsp_rdata", rsp_rdata, 32'd0);
        check32("rst_rsp_err",   32'(rsp_err), 32'd0);
        check32("rst_in_ready",  32'(in_ready), 32'd1);
        rstn = 1'b1;
        idle(2);

        // RAM store / load, ready low through RD_WAIT and RESP
        issue("st_10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        idle(1);
        issue("st_00", 1'b1, 32'h0, 32'h0BADF00D, 32'h0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        idle(1);
        issue("ld_10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        check32("ready_rdwait", 32'(req_ready), 32'd0);
        @(negedge clk);
        check32("ready_resp", 32'(req_ready), 32'd0);
        @(negedge clk);
        check32("ready_after", 32'(req_ready), 32'd1);

        // FIFO basic
        feed_q = '{8'h41, 8'h42, 8'h43};
        feed();
        issue("stat_3", 1'b0, IO_STAT, 32'h0, 32'h00000301, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        issue("pop_41", 1'b0, IO_BASE, 32'h0, 32'h41, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        issue("pop_42", 1'b0, IO_BASE, 32'h0, 32'h42, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        issue("pop_43", 1'b0, IO_BASE, 32'h0, 32'h43, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        issue("pop_empty", 1'b0, IO_BASE, 32'h0, 32'h0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        issue("stat_0a", 1'b0, IO_STAT, 32'h0, 32'h0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        issue("st_fifo", 1'b1, IO_BASE, 32'h99, 32'h0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        issue("st_stat", 1'b1, IO_STAT, 32'hFFFF, 32'h0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        issue("stat_0b", 1'b0, IO_STAT, 32'h0, 32'h0, 1'b0, 1, 1'b1, 1'b0, 1'b0);

        // FIFO full with in_valid held, then wrap
        feed_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59};
        fork
            feed();
        join_none
        waited = 0;
        while (feed_q.size() > 2 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        idle(2);
        check32("full_in_ready", 32'(in_ready), 32'd0);
        check32("full_pending", 32'(feed_q.size()), 32'd2);
        issue("stat_full", 1'b0, IO_STAT, 32'h0, 32'h00000803, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        issue("pop_50", 1'b0, IO_BASE, 32'h0, 32'h50, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        idle(2);
        issue("stat_refill", 1'b0, IO_STAT, 32'h0, 32'h00000803, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            issue($sformatf("pop_w%0d", i), 1'b0, IO_BASE, 32'h0, 32'(8'h50 + i), 1'b0, 1,
                  1'b1, 1'b0, 1'b0);
        end
        waited = 0;
        while ((feed_q.size() > 0 || in_valid) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        issue("stat_0c", 1'b0, IO_STAT, 32'h0, 32'h0, 1'b0, 1, 1'b1, 1'b0, 1'b0);

        // Error decode, no side effects
        issue("ld_mis", 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        issue("ld_8000", 1'b0, 32'h8000, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        issue("st_8000", 1'b1, 32'h8000, 32'h12345678, 32'h0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        issue("st_mis", 1'b1, 32'h11, 32'h87654321, 32'h0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        issue("st_io8", 1'b1, 32'hFFFF0008, 32'h55, 32'h0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        issue("ld_10b", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        idle(2);
        issue("ld_00", 1'b0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Reset while in RD_WAIT with 3 FIFO bytes
        feed_q = '{8'h61, 8'h62, 8'h63};
        feed();
        issue("st_20", 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        idle(1);
        issue("ld_20_drop", 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        check32("rst2_req_ready", 32'(req_ready), 32'd1);
        check32("rst2_rsp_valid", 32'(rsp_valid), 32'd0);
        check32("rst2_in_ready", 32'(in_ready), 32'd1);
        issue("stat_rst", 1'b0, IO_STAT, 32'h0, 32'h0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        issue("ld_20", 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        idle(2);
        issue("ld_10c", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Same-cycle push and pop at count 4
        feed_q = '{8'h71, 8'h72, 8'h73, 8'h74};
        feed();
        issue("stat_4a", 1'b0, IO_STAT, 32'h0, 32'h00000401, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        idle(1);
        in_valid = 1'b1;
        in_data  = 8'h75;
        issue("pop_71", 1'b0, IO_BASE, 32'h0, 32'h71, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        issue("stat_4b", 1'b0, IO_STAT, 32'h0, 32'h00000401, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            issue($sformatf("pop_7%0d", i), 1'b0, IO_BASE, 32'h0, 32'(8'h70 + i), 1'b0, 1,
                  1'b1, 1'b0, 1'b0);
        end
        issue("stat_0d", 1'b0, IO_STAT, 32'h0, 32'h0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        idle(1);

        // req_valid held high across back-to-back requests
        issue("h_st40", 1'b1, 32'h40, 32'h11111111, 32'h0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        issue("h_ld40", 1'b0, 32'h40, 32'h0, 32'h11111111, 1'b0, 2, 1'b1, 1'b1, 1'b1);
        issue("h_st44", 1'b1, 32'h44, 32'h22222222, 32'h0, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        issue("h_ld44", 1'b0, 32'h44, 32'h0, 32'h22222222, 1'b0, 2, 1'b1, 1'b1, 1'b1);
        issue("h_ld40b", 1'b0, 32'h40, 32'h0, 32'h11111111, 1'b0, 2, 1'b1, 1'b1, 1'b1);
        issue("h_mis", 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b1, 1'b1);
        issue("h_stat", 1'b0, IO_STAT, 32'h0, 32'h0, 1'b0, 1, 1'b1, 1'b0, 1'b1);

        idle(6);
        check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
